// File: rtl/lbm_pkg.sv
// lbm_pkg: shared D2Q9 lattice constants, direction tables and scheduler state encoding
//   D2Q9_Q        number of lattice directions
//   D2Q9_DX/DY    signed unit offsets per direction index
//   sched_state_t stream scheduler FSM states
package lbm_pkg;
   localparam int D2Q9_Q = 9;
   localparam logic signed [1:0] D2Q9_DX [D2Q9_Q] = '{2'b00, 2'b01, 2'b00, 2'b11, 2'b00, 2'b01, 2'b11, 2'b11, 2'b01};
   localparam logic signed [1:0] D2Q9_DY [D2Q9_Q] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b11, 2'b01, 2'b01, 2'b11, 2'b11};
   typedef enum logic [1:0] {IDLE, ISSUE, DONE} sched_state_t;
endpackage

// File: rtl/d2q9_neighbor.sv
// d2q9_neighbor: combinational neighbour address and in-grid flag for one D2Q9 direction
//   x, y   source node coordinates
//   dir    direction index 0..8
//   addr   neighbour node address {y+dy, x+dx}
//   valid  neighbour lies inside the grid (no wrap-around)
module d2q9_neighbor
   import lbm_pkg::*;
#(
   parameter int GRID_X = 16,
   parameter int GRID_Y = 16,
   localparam int XW = $clog2(GRID_X),
   localparam int YW = $clog2(GRID_Y)
) (
   input  logic [XW-1:0]    x,
   input  logic [YW-1:0]    y,
   input  logic [3:0]       dir,
   output logic [XW+YW-1:0] addr,
   output logic             valid
);
   logic signed [1:0] dx, dy;
   logic [XW:0] nx;
   logic [YW:0] ny;
   assign dx = D2Q9_DX[dir];
   assign dy = D2Q9_DY[dir];
   // One extra bit: both -1 and GRID_X land with the top bit set, flagging out-of-grid.
   assign nx = {1'b0, x} + {{(XW-1){dx[1]}}, dx};
   assign ny = {1'b0, y} + {{(YW-1){dy[1]}}, dy};
   assign valid = !nx[XW] && !ny[YW];
   assign addr = {ny[YW-1:0], nx[XW-1:0]};
endmodule

// File: rtl/stream_scheduler.sv
// stream_scheduler: issues one f_in write per in-grid D2Q9 neighbour of a latched node
//   Clk, Reset   clock, asynchronous active-low reset
//   start        request to stream node_addr (accepted only when idle)
//   node_addr    source node index {y, x}
//   wr_ready     f_in memory accepts the write this cycle
//   fin_we       f_in write enable
//   fin_addr     destination neighbour address
//   fin_dir      direction index, selects f_out register and f_in bank
//   busy         operation in progress (ISSUE or DONE)
//   done         one-cycle completion pulse
//   wr_count     writes accepted for the last or current node
module stream_scheduler
   import lbm_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int GRID_X = 16,
   parameter int GRID_Y = 16,
   parameter int GRID_DIM = GRID_X * GRID_Y,
   parameter int ADDRESS_WIDTH = $clog2(GRID_DIM)
) (
   input  logic                     Clk,
   input  logic                     Reset,
   input  logic                     start,
   input  logic [ADDRESS_WIDTH-1:0] node_addr,
   input  logic                     wr_ready,
   output logic                     fin_we,
   output logic [ADDRESS_WIDTH-1:0] fin_addr,
   output logic [3:0]               fin_dir,
   output logic                     busy,
   output logic                     done,
   output logic [3:0]               wr_count
);
   localparam int XW = $clog2(GRID_X);
   localparam logic [3:0] LAST_DIR = 4'(D2Q9_Q - 1);
   // A grid that is not a power of two cannot be addressed by concatenation, so it never starts.
   localparam bit CFG_OK = DATA_WIDTH > 0 && (GRID_X & (GRID_X - 1)) == 0 && (GRID_Y & (GRID_Y - 1)) == 0;
   sched_state_t state, state_n;
   logic [3:0] dir;
   logic [ADDRESS_WIDTH-1:0] addr_q, nb_addr;
   logic nb_valid, accept, advance;
   d2q9_neighbor #(.GRID_X(GRID_X), .GRID_Y(GRID_Y)) u_nb (
      .x(addr_q[XW-1:0]),
      .y(addr_q[ADDRESS_WIDTH-1:XW]),
      .dir(dir),
      .addr(nb_addr),
      .valid(nb_valid)
   );
   always_comb begin
      accept = state == IDLE && start && CFG_OK;
      advance = state == ISSUE && (!nb_valid || wr_ready);
      state_n = state;
      case (state)
         IDLE:    state_n = accept ? ISSUE : IDLE;
         ISSUE:   state_n = advance && dir == LAST_DIR ? DONE : ISSUE;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state <= IDLE;
         dir <= '0;
         addr_q <= '0;
         wr_count <= '0;
      end else begin
         state <= state_n;
         if (accept) begin
            addr_q <= node_addr;
            dir <= '0;
            wr_count <= '0;
         end else if (advance) begin
            dir <= dir == LAST_DIR ? 4'd0 : dir + 4'd1;
            wr_count <= nb_valid ? wr_count + 4'd1 : wr_count;
         end
      end
   end
   assign fin_we = state == ISSUE && nb_valid;
   assign fin_addr = state == ISSUE ? nb_addr : '0;
   assign fin_dir = state == ISSUE ? dir : 4'd0;
   assign busy = state != IDLE;
   assign done = state == DONE;
endmodule

// File: tb/tb_stream_scheduler.sv
// tb_stream_scheduler: directed checks of the D2Q9 stream scheduler
module tb_stream_scheduler;
   logic Clk = 0, Reset = 1, start = 0, wr_ready = 1;
   logic [7:0] node_addr = '0;
   logic fin_we, busy, done;
   logic [7:0] fin_addr;
   logic [3:0] fin_dir, wr_count;
   int vec = 0, errs = 0;
   int nodes [4] = '{17, 0, 255, 8};
   logic [8:0] masks [4] = '{9'h1FF, 9'h027, 9'h099, 9'h06F};
   int exp_a [4][9] = '{'{17, 18, 33, 16, 1, 34, 32, 0, 2},
                        '{0, 1, 16, 0, 0, 17, 0, 0, 0},
                        '{255, 0, 0, 254, 239, 0, 0, 238, 0},
                        '{8, 9, 24, 7, 0, 25, 23, 0, 0}};
   int counts [4] = '{9, 4, 4, 6};

   stream_scheduler dut (
      .Clk(Clk), .Reset(Reset), .start(start), .node_addr(node_addr), .wr_ready(wr_ready),
      .fin_we(fin_we), .fin_addr(fin_addr), .fin_dir(fin_dir), .busy(busy), .done(done),
      .wr_count(wr_count)
   );

   always #5 Clk = ~Clk;

   task automatic tick;
      @(posedge Clk);
      #1;
   endtask

   // Leaves the bench sampling in cycle 1 (first ISSUE cycle).
   task automatic go(input int a);
      @(negedge Clk);
      start = 1;
      node_addr = 8'(a);
      tick();
      start = 0;
   endtask

   task automatic test_reset;
      #2 Reset = 0;
      #1;
      vec++;
      if ({fin_we, fin_addr, fin_dir, busy, done, wr_count} !== '0) begin
         errs++;
         $display("FAIL reset: we=%b addr=%0d dir=%0d busy=%b done=%b cnt=%0d, want all 0", fin_we, fin_addr, fin_dir, busy, done, wr_count);
      end
      repeat (2) tick();
      @(negedge Clk) Reset = 1;
      tick();
      vec++;
      if ({fin_we, busy, done} !== 3'b000) begin
         errs++;
         $display("FAIL idle_after_reset: we=%b busy=%b done=%b, want 000", fin_we, busy, done);
      end
   endtask

   task automatic test_stream_nodes;
      for (int n = 0; n < 4; n++) begin
         go(nodes[n]);
         for (int d = 0; d < 9; d++) begin
            vec++;
            if (fin_dir !== 4'(d) || fin_we !== masks[n][d] || busy !== 1'b1 || done !== 1'b0) begin
               errs++;
               $display("FAIL node%0d_dir%0d: dir=%0d we=%b busy=%b done=%b, want dir=%0d we=%b busy=1 done=0", nodes[n], d, fin_dir, fin_we, busy, done, d, masks[n][d]);
            end
            if (masks[n][d]) begin
               vec++;
               if (fin_addr !== 8'(exp_a[n][d])) begin
                  errs++;
                  $display("FAIL node%0d_addr%0d: got %0d want %0d", nodes[n], d, fin_addr, exp_a[n][d]);
               end
            end
            tick();
         end
         vec++;
         if (done !== 1'b1 || busy !== 1'b1 || fin_we !== 1'b0 || fin_addr !== 8'd0 || fin_dir !== 4'd0) begin
            errs++;
            $display("FAIL node%0d_done: done=%b busy=%b we=%b addr=%0d dir=%0d, want 1 1 0 0 0", nodes[n], done, busy, fin_we, fin_addr, fin_dir);
         end
         tick();
         vec++;
         if (done !== 1'b0 || busy !== 1'b0 || wr_count !== 4'(counts[n])) begin
            errs++;
            $display("FAIL node%0d_end: done=%b busy=%b cnt=%0d, want 0 0 %0d", nodes[n], done, busy, wr_count, counts[n]);
         end
      end
   endtask

   task automatic test_backpressure;
      int d;
      go(17);
      for (int c = 1; c <= 13; c++) begin
         wr_ready = !(c >= 3 && c <= 5);
         d = c <= 3 ? c - 1 : (c <= 6 ? 2 : c - 4);
         vec++;
         if (c < 13 && (fin_dir !== 4'(d) || fin_we !== 1'b1 || fin_addr !== 8'(exp_a[0][d]) || done !== 1'b0)) begin
            errs++;
            $display("FAIL bp_c%0d: dir=%0d we=%b addr=%0d done=%b, want dir=%0d we=1 addr=%0d done=0", c, fin_dir, fin_we, fin_addr, done, d, exp_a[0][d]);
         end else if (c == 13 && done !== 1'b1) begin
            errs++;
            $display("FAIL bp_done: done=%b at cycle 13, want 1", done);
         end
         tick();
      end
      wr_ready = 1;
      vec++;
      if (wr_count !== 4'd9 || busy !== 1'b0) begin
         errs++;
         $display("FAIL bp_count: cnt=%0d busy=%b, want 9 0", wr_count, busy);
      end
   endtask

   task automatic test_start_while_busy;
      int dones = 0;
      go(17);
      for (int c = 1; c <= 15; c++) begin
         start = c == 4;
         node_addr = c == 4 ? 8'd100 : 8'd17;
         if (done) dones++;
         if (c <= 9) begin
            vec++;
            if (fin_addr !== 8'(exp_a[0][c-1]) || fin_we !== 1'b1) begin
               errs++;
               $display("FAIL busy_start_c%0d: addr=%0d we=%b, want %0d 1", c, fin_addr, fin_we, exp_a[0][c-1]);
            end
         end
         tick();
      end
      start = 0;
      vec++;
      if (dones != 1 || busy !== 1'b0) begin
         errs++;
         $display("FAIL busy_start_dones: dones=%0d busy=%b, want 1 0", dones, busy);
      end
   endtask

   task automatic test_reset_mid_op;
      int dones = 0;
      go(17);
      repeat (4) tick();
      Reset = 0;
      #1;
      vec++;
      if ({fin_we, fin_addr, fin_dir, busy, done, wr_count} !== '0) begin
         errs++;
         $display("FAIL midreset: we=%b addr=%0d dir=%0d busy=%b done=%b cnt=%0d, want all 0", fin_we, fin_addr, fin_dir, busy, done, wr_count);
      end
      repeat (3) tick();
      @(negedge Clk) Reset = 1;
      for (int c = 0; c < 12; c++) begin
         if (done || fin_we) dones++;
         tick();
      end
      vec++;
      if (dones != 0 || busy !== 1'b0) begin
         errs++;
         $display("FAIL midreset_quiet: activity=%0d busy=%b, want 0 0", dones, busy);
      end
      go(17);
      for (int c = 1; c <= 9; c++) begin
         vec++;
         if (fin_addr !== 8'(exp_a[0][c-1]) || fin_we !== 1'b1 || fin_dir !== 4'(c-1)) begin
            errs++;
            $display("FAIL fresh_c%0d: addr=%0d we=%b dir=%0d, want %0d 1 %0d", c, fin_addr, fin_we, fin_dir, exp_a[0][c-1], c-1);
         end
         tick();
      end
      vec++;
      if (done !== 1'b1) begin
         errs++;
         $display("FAIL fresh_done: done=%b want 1", done);
      end
      tick();
      vec++;
      if (wr_count !== 4'd9 || busy !== 1'b0) begin
         errs++;
         $display("FAIL fresh_count: cnt=%0d busy=%b, want 9 0", wr_count, busy);
      end
   endtask

   initial begin
      test_reset();
      test_stream_nodes();
      test_backpressure();
      test_start_while_busy();
      test_reset_mid_op();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end
endmodule
